// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: op codes, error codes,
// FSM state encoding and small op-classification helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LB  = 3'd1,
    LSU_LBU = 3'd2,
    LSU_LH  = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SW  = 3'd5,
    LSU_SB  = 3'd6,
    LSU_SH  = 3'd7
  } lsu_op_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_store(input lsu_op_e op);
    logic res;
    res = (op == LSU_SW) || (op == LSU_SB) || (op == LSU_SH);
    return res;
  endfunction

  // Halves need an even address, words need the low two bits clear.
  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
    logic res;
    res = 1'b0;
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: res = lo[0];
      LSU_LW, LSU_SW:          res = (lo != 2'b00);
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result alignment: picks the big-endian byte/half lane out of the
// returned memory word and sign- or zero-extends it. Stores yield zero.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_op_e     op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection (lane 0 is the most significant byte) and extension
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[15:0] : word[31:16];

    result = 32'h0000_0000;
    case (op)
      LSU_LW:  result = word;
      LSU_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: result = {24'h00_0000, byte_sel};
      LSU_LH:  result = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: result = {16'h0000, half_sel};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port data memory.
// IDLE -> ACCESS (hold request until ack or timeout) -> RESP (done pulse).
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests skip the
// memory cycle and complete with err=1; otherwise low address bits that do
// not fit the access size are ignored.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e        state, state_nxt;
  lsu_op_e           req_op_e;
  lsu_op_e           op_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt;
  logic              trap;
  logic              start_acc, start_trap, ack_hit, to_hit;
  logic [3:0]        be_nxt;
  logic [31:0]       wdata_nxt;
  logic [31:0]       load_res;

  assign req_op_e = lsu_op_e'(req_op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_op_e, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, stall/done and the per-cycle events the datapath acts on
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    start_trap = 1'b0;
    ack_hit    = 1'b0;
    to_hit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && rst_n) begin
          stall = 1'b1;
          if (trap) begin
            start_trap = 1'b1;
            state_nxt  = ST_RESP;
          end else begin
            start_acc = 1'b1;
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        // An ack on the last allowed cycle still counts as success.
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte enables and replicated store data for the incoming request
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'h0000_0000;
    case (req_op_e)
      LSU_LB, LSU_LBU, LSU_SB: be_nxt = 4'b1000 >> req_addr[1:0];
      LSU_LH, LSU_LHU, LSU_SH: be_nxt = req_addr[1] ? 4'b0011 : 4'b1100;
      default:                 be_nxt = 4'b1111;
    endcase
    case (req_op_e)
      LSU_SW:  wdata_nxt = req_wdata;
      LSU_SB:  wdata_nxt = {4{req_wdata[7:0]}};
      LSU_SH:  wdata_nxt = {2{req_wdata[15:0]}};
      default: wdata_nxt = 32'h0000_0000;
    endcase
  end

  lsu_load_align u_load_align (
    .word    (mem_rdata),
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .result  (load_res)
  );

  // Memory handshake registers, timeout counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      op_q      <= LSU_LW;
      addr_lo_q <= 2'b00;
      cnt       <= '0;
      err       <= ERR_OK;
      rdata     <= 32'h0000_0000;
    end else begin
      if (start_acc) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store(req_op_e);
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        op_q      <= req_op_e;
        addr_lo_q <= req_addr[1:0];
        cnt       <= '0;
      end
      if (start_trap) begin
        err   <= ERR_MISALIGN;
        rdata <= 32'h0000_0000;
      end
      if (ack_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        rdata   <= load_res;
        err     <= ERR_OK;
      end else if (to_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        rdata   <= 32'h0000_0000;
        err     <= ERR_TIMEOUT;
      end else if (state == ST_ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Response fields are only meaningful alongside done.
      if (state == ST_RESP) begin
        err   <= ERR_OK;
        rdata <= 32'h0000_0000;
      end
    end
  end

endmodule
